// File: rtl/bus_arbiter.sv
// ---------------------------------------------------------------------------
// bus_arbiter
//
// Round-robin arbiter for the shared 64-bit bus. One master owns the bus at a
// time. The owner keeps its grant while it keeps requesting, up to MAX_HOLD
// consecutive cycles. Every change of owner goes through a one-cycle
// turnaround with no grant, so two masters never drive the bus together.
//
// Handshake: req[i] is a level. A master raises req[i] and must hold it until
// gnt[i] rises. It keeps req[i] high for as long as it needs the bus. Dropping
// req[i] gives the bus back: gnt[i] falls on the next clock edge.
//
// Ports
//   clkA     in   1     single clock, rising edge
//   reset    in   1     asynchronous, active-low reset
//   req      in   NREQ  request levels; req[0] belongs to device A
//   gnt      out  NREQ  registered grant, one-hot or zero; gnt[0] is gntA
//   busy     out  1     registered, equals |gnt
//   owner    out  IDXW  current owner, or the last owner while idle
//   timeout  out  1     one-cycle pulse when a tenure hits MAX_HOLD
// ---------------------------------------------------------------------------
module bus_arbiter #(
    parameter int NREQ     = 4,
    parameter int MAX_HOLD = 16,
    parameter int IDXW     = $clog2(NREQ)
) (
    input  logic            clkA,
    input  logic            reset,
    input  logic [NREQ-1:0] req,
    output logic [NREQ-1:0] gnt,
    output logic            busy,
    output logic [IDXW-1:0] owner,
    output logic            timeout
);

    localparam int unsigned    NREQ_U    = NREQ;
    localparam int             HOLDW     = $clog2(MAX_HOLD);
    localparam logic [HOLDW-1:0] HOLD_LAST = HOLDW'(MAX_HOLD - 1);

    // IDLE : bus free, arbitrating every cycle
    // GRANT: one master owns the bus
    // TURN : the single dead cycle after a tenure; it also arbitrates
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        TURN  = 2'd2
    } arbState;

    arbState          state;
    arbState          stateNext;

    logic [IDXW-1:0]  ptr;
    logic [IDXW-1:0]  ptrNext;
    logic [IDXW-1:0]  selIdx;
    logic [IDXW-1:0]  ownerNext;
    logic [HOLDW-1:0] holdCnt;
    logic [HOLDW-1:0] holdNext;
    logic [NREQ-1:0]  gntNext;
    logic             busyNext;
    logic             timeoutNext;
    logic             anyReq;
    logic             ownerReq;
    logic             holdAtLimit;

    // (base + offs) mod NREQ. The caller keeps both operands below NREQ,
    // so a single conditional subtract is enough, even when NREQ is not a
    // power of two.
    function automatic logic [IDXW-1:0] wrapIdx(input logic [IDXW-1:0] base,
                                                input int unsigned      offs);
        int unsigned sum;
        sum = 32'(base) + offs;
        if (sum >= NREQ_U) begin
            sum = sum - NREQ_U;
        end
        return IDXW'(sum);
    endfunction

    assign anyReq      = |req;
    assign ownerReq    = req[owner];
    assign holdAtLimit = (holdCnt == HOLD_LAST);

    // Circular priority scan that starts at ptr. The loop walks from the
    // farthest candidate back to ptr, so the last hit, which is the nearest
    // one, wins.
    always_comb begin
        selIdx = ptr;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req[wrapIdx(ptr, unsigned'(i))]) begin
                selIdx = wrapIdx(ptr, unsigned'(i));
            end
        end
    end

    // State register, together with the registered outputs and the counters.
    always_ff @(posedge clkA or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            ptr     <= '0;
            holdCnt <= '0;
            gnt     <= '0;
            busy    <= 1'b0;
            owner   <= '0;
            timeout <= 1'b0;
        end else begin
            state   <= stateNext;
            ptr     <= ptrNext;
            holdCnt <= holdNext;
            gnt     <= gntNext;
            busy    <= busyNext;
            owner   <= ownerNext;
            timeout <= timeoutNext;
        end
    end

    // Next-state logic.
    always_comb begin
        stateNext = state;
        case (state)
            IDLE: begin
                if (anyReq) begin
                    stateNext = GRANT;
                end
            end
            GRANT: begin
                if (!ownerReq || holdAtLimit) begin
                    stateNext = TURN;
                end
            end
            TURN: begin
                stateNext = anyReq ? GRANT : IDLE;
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    // Output and datapath next values. They are registered above, so gnt
    // never comes straight from req.
    always_comb begin
        gntNext     = gnt;
        busyNext    = busy;
        ownerNext   = owner;
        ptrNext     = ptr;
        holdNext    = holdCnt;
        timeoutNext = 1'b0;
        case (state)
            IDLE, TURN: begin
                gntNext  = '0;
                busyNext = 1'b0;
                if (anyReq) begin
                    gntNext[selIdx] = 1'b1;
                    busyNext        = 1'b1;
                    ownerNext       = selIdx;
                    holdNext        = '0;
                end
            end
            GRANT: begin
                if (!ownerReq) begin
                    // A normal release wins over the limit. Dropping req on
                    // the last allowed cycle never raises timeout.
                    gntNext  = '0;
                    busyNext = 1'b0;
                    ptrNext  = wrapIdx(owner, 1);
                end else if (holdAtLimit) begin
                    gntNext     = '0;
                    busyNext    = 1'b0;
                    timeoutNext = 1'b1;
                    ptrNext     = wrapIdx(owner, 1);
                end else begin
                    holdNext = holdCnt + 1'b1;
                end
            end
            default: begin
                gntNext  = '0;
                busyNext = 1'b0;
            end
        endcase
    end

endmodule
